// File: rtl/xpb_digit_accum.sv
// Digit sequencer and widened accumulator around the xpb LUT bank.
// Issues one overflow digit per cycle and sums the returned residues.
module xpb_digit_accum #(
  parameter int NUM_DIGITS = 8,
  parameter int DIGIT_W    = 5,
  parameter int DATA_W     = 1024,
  parameter int IDX_W      = 3,
  parameter int SUM_W      = DATA_W + IDX_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] ovf_in,
  output logic [DIGIT_W-1:0]            lut_sel,
  output logic [IDX_W-1:0]              lut_idx,
  output logic                          lut_vld,
  input  logic [DATA_W-1:0]             lut_data,
  output logic                          busy,
  output logic                          done,
  output logic [SUM_W-1:0]              sum_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [IDX_W-1:0]                r_cnt;
  logic [NUM_DIGITS*DIGIT_W-1:0]   r_ovf;
  logic                            r_acc_vld;
  logic [SUM_W-1:0]                r_sum;
  logic                            w_accept;
  logic                            w_last;
  logic [DIGIT_W-1:0]              w_digit [NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_digit[gi] = r_ovf[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
      S_ISSUE: if (w_last)   w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = S_DONE;
      S_DONE:  w_state_next = w_accept ? S_ISSUE : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    lut_vld = 1'b0;
    lut_sel = '0;
    lut_idx = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_ISSUE: begin
        lut_vld = 1'b1;
        lut_sel = w_digit[r_cnt];
        lut_idx = r_cnt;
        busy    = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_ovf <= ovf_in;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // LUT is registered, so its result lines up with the previous cycle's issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_vld <= 1'b0;
      r_sum     <= '0;
    end else begin
      r_acc_vld <= lut_vld;
      if (w_accept)       r_sum <= '0;
      else if (r_acc_vld) r_sum <= r_sum + {{(SUM_W-DATA_W){1'b0}}, lut_data};
    end
  end

  assign sum_out = r_sum;

endmodule

// File: tb/tb_xpb_digit_accum.sv
// Directed scoreboard bench for xpb_digit_accum with a registered LUT model.
module tb_xpb_digit_accum;
  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 5;
  localparam int DATA_W     = 1024;
  localparam int IDX_W      = 3;
  localparam int SUM_W      = DATA_W + IDX_W;
  localparam int OVF_W      = NUM_DIGITS * DIGIT_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [OVF_W-1:0]  ovf_in;
  logic [DIGIT_W-1:0] lut_sel;
  logic [IDX_W-1:0]  lut_idx;
  logic              lut_vld;
  logic [DATA_W-1:0] lut_data;
  logic              busy;
  logic              done;
  logic [SUM_W-1:0]  sum_out;

  int checks   = 0;
  int failures = 0;
  int lut_mode = 0;

  logic [DIGIT_W-1:0] sel_q [$];
  logic [SUM_W-1:0]   sum_q [$];

  xpb_digit_accum #(
    .NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W), .DATA_W(DATA_W),
    .IDX_W(IDX_W), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ovf_in(ovf_in),
    .lut_sel(lut_sel), .lut_idx(lut_idx), .lut_vld(lut_vld),
    .lut_data(lut_data), .busy(busy), .done(done), .sum_out(sum_out)
  );

  always #5 clk = ~clk;

  // Registered LUT model; returns junk for idle slots so gating is exercised.
  always @(posedge clk) begin
    if (!lut_vld) lut_data <= {(DATA_W/4){4'hA}};
    else case (lut_mode)
      1:       lut_data <= (lut_sel != '0) ? DATA_W'(lut_idx) + DATA_W'(1) : '0;
      2:       lut_data <= {DATA_W{1'b1}};
      3:       lut_data <= DATA_W'(lut_sel);
      default: lut_data <= '0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [SUM_W-1:0] obs, input logic [SUM_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [SUM_W-1:0] model_sum(input logic [OVF_W-1:0] ovf, input int mode);
    logic [SUM_W-1:0] s;
    logic [DIGIT_W-1:0] d;
    s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = ovf[i*DIGIT_W +: DIGIT_W];
      case (mode)
        1: if (d != '0) s = s + SUM_W'(i + 1);
        2: s = s + {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
        3: s = s + SUM_W'(d);
        default: ;
      endcase
    end
    return s;
  endfunction

  // Starts at the current negedge (cycle 0) and returns at the done cycle's negedge.
  task automatic do_op(input logic [OVF_W-1:0] ovf, input int mode, input int inj_cyc,
                       input logic [OVF_W-1:0] inj_ovf);
    logic [DIGIT_W-1:0] exp_sel;
    logic [SUM_W-1:0]   exp_sum;
    lut_mode = mode;
    for (int i = 0; i < NUM_DIGITS; i++) sel_q.push_back(ovf[i*DIGIT_W +: DIGIT_W]);
    sum_q.push_back(model_sum(ovf, mode));
    start  = 1'b1;
    ovf_in = ovf;
    @(negedge clk);
    start  = 1'b0;
    ovf_in = {$urandom, 8'h5A};
    for (int c = 1; c <= NUM_DIGITS + 1; c++) begin
      if (c == inj_cyc) begin
        start  = 1'b1;
        ovf_in = inj_ovf;
      end
      chk($sformatf("busy_c%0d", c), SUM_W'(busy), SUM_W'(1));
      chk($sformatf("done_c%0d", c), SUM_W'(done), SUM_W'(0));
      chk($sformatf("vld_c%0d", c), SUM_W'(lut_vld), SUM_W'(c <= NUM_DIGITS));
      if (c == 1) chk("sum_clear", sum_out, '0);
      if (c <= NUM_DIGITS) begin
        exp_sel = sel_q.pop_front();
        chk($sformatf("idx_c%0d", c), SUM_W'(lut_idx), SUM_W'(c - 1));
        chk($sformatf("sel_c%0d", c), SUM_W'(lut_sel), SUM_W'(exp_sel));
      end
      @(negedge clk);
      start = 1'b0;
    end
    exp_sum = sum_q.pop_front();
    chk("done_pulse", SUM_W'(done), SUM_W'(1));
    chk("busy_done", SUM_W'(busy), SUM_W'(0));
    chk("vld_done", SUM_W'(lut_vld), SUM_W'(0));
    chk("sum_final", sum_out, exp_sum);
    $display("op mode=%0d ovf=%0h sum=%0h exp=%0h", mode, ovf, sum_out, exp_sum);
  endtask

  initial begin
    logic [OVF_W-1:0] ovf_seq;
    logic [SUM_W-1:0] held;
    reset  = 1'b1;
    start  = 1'b0;
    ovf_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", SUM_W'(busy), '0);
    chk("rst_done", SUM_W'(done), '0);
    chk("rst_vld", SUM_W'(lut_vld), '0);
    chk("rst_sel", SUM_W'(lut_sel), '0);
    chk("rst_idx", SUM_W'(lut_idx), '0);
    chk("rst_sum", sum_out, '0);
    reset = 1'b0;
    @(negedge clk);

    // Zero LUT, zero word; then check done does not repeat and the sum holds.
    do_op('0, 0, 0, '0);
    held = sum_out;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_once", SUM_W'(done), '0);
      chk("sum_hold", sum_out, held);
    end

    // idx+1 LUT on all-ones, then back-to-back all-ones LUT starting in the done cycle.
    do_op({OVF_W{1'b1}}, 1, 0, '0);
    do_op({OVF_W{1'b1}}, 2, 0, '0);
    chk("sum_top", SUM_W'(sum_out[SUM_W-1 -: 3]), SUM_W'(3'b111));
    chk("sum_low", SUM_W'(sum_out[3:0]), SUM_W'(4'h8));
    @(negedge clk);

    // Digit i = i+1; a mid-operation start with another word must be ignored.
    for (int i = 0; i < NUM_DIGITS; i++) ovf_seq[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(i + 1);
    do_op(ovf_seq, 3, 4, {OVF_W{1'b1}});
    chk("seq_sum", sum_out, SUM_W'(36));
    @(negedge clk);

    // Reset in cycle 5 of an operation.
    lut_mode = 2;
    start    = 1'b1;
    ovf_in   = ovf_seq;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", SUM_W'(busy), '0);
    chk("mid_rst_vld", SUM_W'(lut_vld), '0);
    chk("mid_rst_sum", sum_out, '0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("mid_rst_nodone%0d", k), SUM_W'(done), '0);
      @(negedge clk);
    end
    chk("mid_rst_sum_after", sum_out, '0);

    // Normal operation after the aborted one.
    do_op({$urandom, 8'hC3}, 3, 0, '0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
